// File: rtl/pulse_window_counter_pkg.sv
// Shared definitions for the pulse window counter: FSM state encoding and default sizes.
// Optional saturation is enabled by defining PWC_SAT_EN.
package pulse_window_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LATCH = 2'd2
    } pwc_state_e;

    localparam int PWC_NCH_DEF     = 2;
    localparam int PWC_CNT_W_DEF   = 24;
    localparam int PWC_WIN_LEN_DEF = 20000;
    localparam int PWC_WIN_W_DEF   = 16;

endpackage

// File: rtl/pulse_window_counter_channel.sv
// One trigger channel: a high-count / low-count pair advanced on qualified ce pulses.
// With PWC_SAT_EN defined the counters stick at all-ones and report it; otherwise they wrap.
module pulse_window_counter_channel
    import pulse_window_counter_pkg::*;
#(
    parameter int CNT_W = PWC_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             trigger,
    input  logic             clr,
    output logic [CNT_W-1:0] p_next,
    output logic [CNT_W-1:0] m_next
`ifdef PWC_SAT_EN
    ,
    output logic             sat_next
`endif
);

    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] m_q, m_d;

`ifdef PWC_SAT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic sat_q, sat_d;
`endif

    // p_next/m_next include the current sample so the top can latch the terminal ce directly.
    always_comb begin
        p_next = p_q;
        m_next = m_q;
`ifdef PWC_SAT_EN
        sat_next = sat_q;
`endif
        if (ce) begin
            if (trigger) begin
`ifdef PWC_SAT_EN
                if (p_q == CNT_MAX) sat_next = 1'b1;
                else                p_next   = p_q + 1'b1;
`else
                p_next = p_q + 1'b1;
`endif
            end else begin
`ifdef PWC_SAT_EN
                if (m_q == CNT_MAX) sat_next = 1'b1;
                else                m_next   = m_q + 1'b1;
`else
                m_next = m_q + 1'b1;
`endif
            end
        end
        p_d = clr ? '0 : p_next;
        m_d = clr ? '0 : m_next;
`ifdef PWC_SAT_EN
        sat_d = clr ? 1'b0 : sat_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q <= '0;
            m_q <= '0;
`ifdef PWC_SAT_EN
            sat_q <= 1'b0;
`endif
        end else begin
            p_q <= p_d;
            m_q <= m_d;
`ifdef PWC_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

endmodule

// File: rtl/pulse_window_counter.sv
// Multi-channel windowed pulse counter with a valid/ready result buffer and sticky overrun.
// Defining PWC_SAT_EN makes the counters saturate and adds the sat_flag output.
module pulse_window_counter
    import pulse_window_counter_pkg::*;
#(
    parameter int NCH     = PWC_NCH_DEF,
    parameter int CNT_W   = PWC_CNT_W_DEF,
    parameter int WIN_LEN = PWC_WIN_LEN_DEF,
    parameter int WIN_W   = PWC_WIN_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 start,
    input  logic                 cont,
    input  logic [NCH-1:0]       trigger,
    output logic [NCH*CNT_W-1:0] count_p,
    output logic [NCH*CNT_W-1:0] count_m,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 overrun,
    output logic                 busy
`ifdef PWC_SAT_EN
    ,
    output logic [NCH-1:0]       sat_flag
`endif
);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    pwc_state_e           state_q, state_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [NCH*CNT_W-1:0] count_p_q, count_p_d;
    logic [NCH*CNT_W-1:0] count_m_q, count_m_d;
    logic                 res_valid_q, res_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic [NCH*CNT_W-1:0] p_next, m_next;
    logic                 cnt_en, terminal, handshake;

`ifdef PWC_SAT_EN
    logic [NCH-1:0] sat_next;
    logic [NCH-1:0] sat_flag_q, sat_flag_d;
`endif

    assign cnt_en    = (state_q == ST_RUN) && ce;
    assign terminal  = cnt_en && (win_q == WIN_LAST);
    assign handshake = res_valid_q && res_ready;

    // Working counters clear on the same edge that captures their final values.
    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        pulse_window_counter_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .ce      (cnt_en),
            .trigger (trigger[ch]),
            .clr     (terminal),
            .p_next  (p_next[ch*CNT_W +: CNT_W]),
            .m_next  (m_next[ch*CNT_W +: CNT_W])
`ifdef PWC_SAT_EN
            ,
            .sat_next(sat_next[ch])
`endif
        );
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        count_p_d   = count_p_q;
        count_m_d   = count_m_q;
        res_valid_d = res_valid_q && !res_ready;
        overrun_d   = handshake ? 1'b0 : overrun_q;
`ifdef PWC_SAT_EN
        sat_flag_d  = sat_flag_q;
`endif

        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (ce) begin
                    if (win_q == WIN_LAST) begin
                        state_d = ST_LATCH;
                        win_d   = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
            end
            ST_LATCH: state_d = cont ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // An unconsumed result is never overwritten; the new window is dropped instead.
        if (terminal) begin
            if (res_valid_q && !res_ready) begin
                overrun_d = 1'b1;
            end else begin
                count_p_d   = p_next;
                count_m_d   = m_next;
                res_valid_d = 1'b1;
`ifdef PWC_SAT_EN
                sat_flag_d  = sat_next;
`endif
            end
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            count_p_q   <= '0;
            count_m_q   <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PWC_SAT_EN
            sat_flag_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            count_p_q   <= count_p_d;
            count_m_q   <= count_m_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
`ifdef PWC_SAT_EN
            sat_flag_q  <= sat_flag_d;
`endif
        end
    end

    assign count_p   = count_p_q;
    assign count_m   = count_m_q;
    assign res_valid = res_valid_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
`ifdef PWC_SAT_EN
    assign sat_flag  = sat_flag_q;
`endif

endmodule
